pad_playback_reader: RTL and testbench

Playback engine for record mode; reads back the note sequence that record mode stores in the 12-entry x 4-bit SRAM. It steps through SRAM addresses in order and fetches each stored 4-bit key code. It decodes each code back to a one-hot key vector, the inverse of the 12-to-4 key encoder. It drives the tone player (Bin/EN) for a fixed note duration per entry, so a recorded sequence replays without keypad input.

---
 rtl/pad_playback_reader_pkg.sv | 16 +
 rtl/pad_playback_reader_decoder_4_to_12.sv | 20 ++
 rtl/pad_playback_reader.sv | 182 ++++++++++++++++++
 tb/tb_pad_playback_reader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_playback_reader_pkg.sv
// Shared constants and FSM encoding for the record-mode playback reader.
package pad_playback_reader_pkg;

  localparam int         NUM_KEYS      = 12;
  localparam logic [3:0] CODE_REST_MIN = 4'd12;
  localparam logic [3:0] CODE_END      = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_NEXT  = 3'd4
  } state_t;

endpackage

// File: rtl/pad_playback_reader_decoder_4_to_12.sv
// Inverse of the 12-to-4 key encoder: stored key code back to a one-hot key vector.
module decoder_4_to_12
  import pad_playback_reader_pkg::*;
(
  input  logic [3:0]          code,
  output logic [NUM_KEYS-1:0] onehot,
  output logic                valid
);

  // codes 12..15 are rests / end marker and decode to no key
  always_comb begin
    valid = (code < CODE_REST_MIN);
    if (valid) begin
      onehot = {{(NUM_KEYS-1){1'b0}}, 1'b1} << code;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/pad_playback_reader.sv
// Replays the recorded key-code sequence from SRAM into the tone player, one
// fixed-length slot per entry, with optional looping.
module pad_playback_reader
  import pad_playback_reader_pkg::*;
#(
  parameter int DEPTH       = 12,
  parameter int ADDR_W      = 4,
  parameter int NOTE_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Start,
  input  logic                Stop,
  input  logic                Loop_en,
  input  logic                RW_busy,
  output logic [ADDR_W-1:0]   Addr,
  output logic                Rd_en,
  input  logic [3:0]          Rd_data,
  output logic [3:0]          Bin,
  output logic                Note_en,
  output logic [NUM_KEYS-1:0] Note_onehot,
  output logic                Busy,
  output logic                Done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NOTE_CYCLES - 1);

  state_t               state_r, state_s;
  logic [ADDR_W-1:0]    addr_r, addr_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic                 rd_en_r, rd_en_s;
  logic [3:0]           bin_r, bin_s;
  logic                 note_en_r, note_en_s;
  logic [NUM_KEYS-1:0]  onehot_r, onehot_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 end_r, end_s;
  logic [NUM_KEYS-1:0]  dec_onehot_s;
  logic                 dec_valid_s;

  decoder_4_to_12 u_decoder (
    .code   (Rd_data),
    .onehot (dec_onehot_s),
    .valid  (dec_valid_s)
  );

  // Next-state and next-output logic; Stop overrides everything outside IDLE.
  // Rd_en is registered, so the read is requested on the transition into the
  // cycle that issues it, letting data arrive in the following WAIT cycle.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    cnt_s     = cnt_r;
    rd_en_s   = 1'b0;
    bin_s     = bin_r;
    note_en_s = note_en_r;
    onehot_s  = onehot_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    end_s     = end_r;
    if ((state_r != ST_IDLE) && Stop) begin
      state_s   = ST_IDLE;
      addr_s    = '0;
      cnt_s     = '0;
      note_en_s = 1'b0;
      onehot_s  = '0;
      busy_s    = 1'b0;
      end_s     = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            state_s = ST_FETCH;
            addr_s  = '0;
            busy_s  = 1'b1;
            end_s   = 1'b0;
            rd_en_s = ~RW_busy;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (rd_en_r) begin
            state_s = ST_WAIT;
          end else if (!RW_busy) begin
            rd_en_s = 1'b1;
          end else begin
            rd_en_s = 1'b0;
          end
        end
        ST_WAIT: begin
          cnt_s = '0;
          if (Rd_data == CODE_END) begin
            end_s   = 1'b1;
            state_s = ST_NEXT;
          end else if (dec_valid_s) begin
            bin_s     = Rd_data;
            onehot_s  = dec_onehot_s;
            note_en_s = 1'b1;
            state_s   = ST_PLAY;
          end else begin
            note_en_s = 1'b0;
            onehot_s  = '0;
            state_s   = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (cnt_r == CNT_LAST) begin
            state_s   = ST_NEXT;
            cnt_s     = '0;
            note_en_s = 1'b0;
            onehot_s  = '0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_NEXT: begin
          if (end_r || (addr_r == LAST_ADDR)) begin
            done_s = 1'b1;
            end_s  = 1'b0;
            if (Loop_en) begin
              addr_s  = '0;
              state_s = ST_FETCH;
              rd_en_s = ~RW_busy;
            end else begin
              busy_s  = 1'b0;
              state_s = ST_IDLE;
            end
          end else begin
            addr_s  = addr_r + ADDR_W'(1);
            state_s = ST_FETCH;
            rd_en_s = ~RW_busy;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          busy_s    = 1'b0;
          note_en_s = 1'b0;
          onehot_s  = '0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= ST_IDLE;
      addr_r    <= '0;
      cnt_r     <= '0;
      rd_en_r   <= 1'b0;
      bin_r     <= 4'd0;
      note_en_r <= 1'b0;
      onehot_r  <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      end_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      cnt_r     <= cnt_s;
      rd_en_r   <= rd_en_s;
      bin_r     <= bin_s;
      note_en_r <= note_en_s;
      onehot_r  <= onehot_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      end_r     <= end_s;
    end
  end

  assign Addr        = addr_r;
  assign Rd_en       = rd_en_r;
  assign Bin         = bin_r;
  assign Note_en     = note_en_r;
  assign Note_onehot = onehot_r;
  assign Busy        = busy_r;
  assign Done        = done_r;

endmodule

// File: tb/tb_pad_playback_reader.sv
// Self-checking bench: random SRAM contents replayed against a slot-schedule model.
module tb_pad_playback_reader;

  localparam int N     = 4;
  localparam int DEPTH = 12;
  localparam int H_MAX = 200;

  logic        CLK = 1'b0;
  logic        RST, Start, Stop, Loop_en, RW_busy;
  logic [3:0]  Addr, Rd_data, Bin;
  logic        Rd_en, Note_en, Busy, Done;
  logic [11:0] Note_onehot;
  logic [23:0] obs;

  int total = 0;
  int bad   = 0;

  logic [3:0]  mem [DEPTH];
  logic [23:0] exp_v [H_MAX+1];
  int          n_emit;
  logic [3:0]  cur_bin;

  always #5 CLK = ~CLK;

  // SRAM model: data one cycle after Rd_en, garbage otherwise
  always @(posedge CLK) Rd_data <= Rd_en ? mem[Addr] : 4'($urandom_range(0, 15));

  assign obs = {Rd_en, Addr, Note_en, Note_onehot, Bin, Busy, Done};

  pad_playback_reader #(.DEPTH(DEPTH), .ADDR_W(4), .NOTE_CYCLES(N), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Stop(Stop), .Loop_en(Loop_en),
    .RW_busy(RW_busy), .Addr(Addr), .Rd_en(Rd_en), .Rd_data(Rd_data), .Bin(Bin),
    .Note_en(Note_en), .Note_onehot(Note_onehot), .Busy(Busy), .Done(Done)
  );

  function automatic void emit(logic rd, logic [3:0] a, logic ne, logic [11:0] oh,
                               logic [3:0] b, logic bz, logic dn);
    n_emit++;
    if (n_emit <= H_MAX) exp_v[n_emit] = {rd, a, ne, oh, b, bz, dn};
  endfunction

  // Expected per-cycle outputs, cycle 1 = first cycle after the Start edge.
  // Each entry: fetch slot, wait slot, N play slots unless end marker, next slot.
  task automatic build(input int horizon, input bit loop_mode);
    int         a = 0;
    logic       pend = 1'b0;
    logic [3:0] code;
    logic [3:0] cb = cur_bin;
    logic       is_note;
    n_emit = 0;
    while (n_emit < horizon) begin
      emit(1'b1, 4'(a), 1'b0, 12'd0, cb, 1'b1, pend);
      pend = 1'b0;
      emit(1'b0, 4'(a), 1'b0, 12'd0, cb, 1'b1, 1'b0);
      code = mem[a];
      is_note = (code < 4'd12);
      if (code != 4'd15) begin
        if (is_note) cb = code;
        for (int k = 0; k < N; k++)
          emit(1'b0, 4'(a), is_note, is_note ? (12'd1 << code) : 12'd0, cb, 1'b1, 1'b0);
      end
      emit(1'b0, 4'(a), 1'b0, 12'd0, cb, 1'b1, 1'b0);
      if (code == 4'd15 || a == DEPTH - 1) begin
        pend = 1'b1;
        if (loop_mode) begin
          a = 0;
        end else begin
          emit(1'b0, 4'(a), 1'b0, 12'd0, cb, 1'b0, 1'b1);
          while (n_emit < horizon) emit(1'b0, 4'(a), 1'b0, 12'd0, cb, 1'b0, 1'b0);
        end
      end else begin
        a++;
      end
    end
  endtask

  task automatic apply_reset();
    Start = 1'b0; Stop = 1'b0; Loop_en = 1'b0; RW_busy = 1'b0;
    @(posedge CLK); #1 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    cur_bin = 4'd0;
  endtask

  // Leaves the bench at cycle 1 (just after the edge that samples Start).
  task automatic pulse_start();
    @(posedge CLK); #1 Start = 1'b1;
    @(posedge CLK); #1 Start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; Start = 1'b0; Stop = 1'b0; Loop_en = 1'b0; RW_busy = 1'b0;
    #3 RST = 1'b0;
    #1 total++;
    if (obs !== 24'd0) begin bad++; $display("FAIL reset_state got=%h want=%h", obs, 24'd0); end
    @(posedge CLK); #1 RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      Stop = 1'($urandom_range(0, 1)); Loop_en = 1'($urandom_range(0, 1));
      RW_busy = 1'($urandom_range(0, 1));
      @(posedge CLK); #1 total++;
      if (obs !== 24'd0) begin bad++; $display("FAIL idle_hold cyc=%0d got=%h want=%h", i, obs, 24'd0); end
    end
    cur_bin = 4'd0;
  endtask

  task automatic test_basic();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom_range(0, 15));
    mem[0] = 4'd3; mem[1] = 4'd7; mem[2] = 4'd15;
    build(30, 1'b0);
    pulse_start();
    for (int t = 1; t <= 30; t++) begin
      if (t > 1) begin @(posedge CLK); #1; end
      total++;
      if (obs !== exp_v[t]) begin bad++; $display("FAIL basic cyc=%0d got=%h want=%h", t, obs, exp_v[t]); end
    end
  endtask

  task automatic test_rest_scan();
    logic [3:0] max_addr = 4'd0;
    apply_reset();
    for (int i = 0; i < DEPTH - 1; i++) mem[i] = 4'($urandom_range(12, 14));
    mem[DEPTH-1] = 4'd11;
    build(100, 1'b0);
    pulse_start();
    for (int t = 1; t <= 100; t++) begin
      if (t > 1) begin @(posedge CLK); #1; end
      if (Addr > max_addr) max_addr = Addr;
      total++;
      if (obs !== exp_v[t]) begin bad++; $display("FAIL rest_scan cyc=%0d got=%h want=%h", t, obs, exp_v[t]); end
    end
    total++;
    if (max_addr !== 4'd11) begin bad++; $display("FAIL max_addr got=%0d want=%0d", max_addr, 11); end
  endtask

  task automatic test_loop();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom_range(0, 15));
    mem[0] = 4'd5; mem[1] = 4'd15;
    Loop_en = 1'b1;
    build(40, 1'b1);
    pulse_start();
    for (int t = 1; t <= 40; t++) begin
      if (t > 1) begin @(posedge CLK); #1; end
      total++;
      if (obs !== exp_v[t]) begin bad++; $display("FAIL loop cyc=%0d got=%h want=%h", t, obs, exp_v[t]); end
    end
    Stop = 1'b1;
    @(posedge CLK); #1 Stop = 1'b0;
    total++;
    if ({Busy, Note_en, Addr, Done, Rd_en} !== 8'd0) begin
      bad++; $display("FAIL loop_stop got=%b want=%b", {Busy, Note_en, Addr, Done, Rd_en}, 8'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1 total++;
      if ({Busy, Done, Rd_en} !== 3'd0) begin bad++; $display("FAIL loop_after_stop got=%b want=000", {Busy, Done, Rd_en}); end
    end
    // all end markers: Done every 3 cycles, no hang
    apply_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'd15;
    Loop_en = 1'b1;
    build(20, 1'b1);
    pulse_start();
    for (int t = 1; t <= 20; t++) begin
      if (t > 1) begin @(posedge CLK); #1; end
      total++;
      if (obs !== exp_v[t]) begin bad++; $display("FAIL loop_all_end cyc=%0d got=%h want=%h", t, obs, exp_v[t]); end
    end
  endtask

  task automatic test_write_block();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom_range(0, 11));
    @(posedge CLK); #1 Start = 1'b1; RW_busy = 1'b1;
    @(posedge CLK); #1 Start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) begin @(posedge CLK); #1; end
      total++;
      if ({Rd_en, Addr, Busy} !== 6'b0_0000_1) begin
        bad++; $display("FAIL wr_block cyc=%0d got=%b want=%b", i, {Rd_en, Addr, Busy}, 6'b0_0000_1);
      end
      if (i == 5) RW_busy = 1'b0;
    end
    @(posedge CLK); #1 total++;
    if ({Rd_en, Addr} !== 5'b1_0000) begin bad++; $display("FAIL wr_issue got=%b want=%b", {Rd_en, Addr}, 5'b1_0000); end
    repeat (2) @(posedge CLK);
    #1 total++;
    if ({Note_en, Bin} !== {1'b1, mem[0]}) begin
      bad++; $display("FAIL wr_note got=%b want=%b", {Note_en, Bin}, {1'b1, mem[0]});
    end
  endtask

  task automatic test_reset_mid_note();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom_range(0, 14));
    mem[0] = 4'($urandom_range(0, 11));
    pulse_start();
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    #1 total++;
    if (obs !== 24'd0) begin bad++; $display("FAIL reset_mid got=%h want=%h", obs, 24'd0); end
    #2 RST = 1'b1;
    cur_bin = 4'd0;
    build(60, 1'b0);
    pulse_start();
    for (int t = 1; t <= 60; t++) begin
      if (t > 1) begin @(posedge CLK); #1; end
      total++;
      if (obs !== exp_v[t]) begin bad++; $display("FAIL after_reset cyc=%0d got=%h want=%h", t, obs, exp_v[t]); end
    end
  endtask

  task automatic test_start_stop();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom_range(0, 11));
    Loop_en = 1'b1;
    build(8, 1'b1);
    pulse_start();
    for (int t = 1; t <= 8; t++) begin
      if (t > 1) begin @(posedge CLK); #1; end
      total++;
      if (obs !== exp_v[t]) begin bad++; $display("FAIL ss_pre cyc=%0d got=%h want=%h", t, obs, exp_v[t]); end
    end
    Start = 1'b1; Stop = 1'b1;
    @(posedge CLK); #1 Start = 1'b0; Stop = 1'b0;
    total++;
    if ({Busy, Note_en, Addr, Done} !== 7'd0) begin
      bad++; $display("FAIL ss_stop got=%b want=%b", {Busy, Note_en, Addr, Done}, 7'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1 total++;
      if ({Busy, Done, Rd_en} !== 3'd0) begin bad++; $display("FAIL ss_no_restart got=%b want=000", {Busy, Done, Rd_en}); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      for (int i = 0; i < DEPTH; i++)
        mem[i] = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      build(110, 1'b0);
      pulse_start();
      for (int t = 1; t <= 110; t++) begin
        if (t > 1) begin @(posedge CLK); #1; end
        total++;
        if (obs !== exp_v[t]) begin bad++; $display("FAIL random run=%0d cyc=%0d got=%h want=%h", r, t, obs, exp_v[t]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rest_scan();
    test_loop();
    test_write_block();
    test_reset_mid_note();
    test_start_stop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
